col2im: RTL and testbench
=========================

# col2im

Inverse of the im2col lowering stage. The block reads an im2col matrix from shared memory, one element per cycle. Each element is added back into its source pixel position of a zero-padded feature map, and contributions that fall on padding are dropped. The accumulated IMG_C x IMG_H x IMG_W image is then written back to memory, one element per cycle. It sits after the GEMM/backward path on the same single-port-style memory bus that the im2col stage uses.

## Interface
- IMG_C, 1, channel count
- IMG_W, 8, image width (pixels)
- IMG_H, 8, image height (pixels)
- DATA_WIDTH, 8, element width; also the address stride per element
- ADDR_WIDTH, 32, address width
- FILTER_SIZE, 3, odd filter edge; P = (FILTER_SIZE-1)/2
- IM2COL_BASE, 16'h2000, base address of the source im2col matrix
- IMG_BASE, 16'h0000, base address of the destination image
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_rd  in  DATA_WIDTH  memory read data; combinational function of addr_rd, sampled at the clock edge
- addr_rd  out  ADDR_WIDTH  read address, registered
- data_wr  out  DATA_WIDTH  write data, registered
- addr_wr  out  ADDR_WIDTH  write address, registered
- mem_wr_en  out  1  write strobe; addr_wr and data_wr are valid in every cycle it is 1
- done  out  1  completion flag, sticky until reset

## Operation
- Notation: K = FILTER_SIZE², NR = IMG_H·IMG_W·IMG_C·K (reads), NW = IMG_C·IMG_H·IMG_W (writes).
- Internal accumulator buffer: NW × DATA_WIDTH, unsigned, cleared in reset and in IDLE.
- **States**
  - IDLE: one cycle, then READING.
  - READING: NR cycles, then WRITING.
  - WRITING: NW cycles, then DONE.
  - DONE: terminal; left only by reset.
- **Read order** (identical to the im2col output order): counters nest from outermost to innermost as row (0..IMG_H-1), col (0..IMG_W-1), ch (0..IMG_C-1), fr (0..FS-1), fc (0..FS-1).
  - Element index k = ((row·IMG_W+col)·IMG_C+ch)·K + fr·FS + fc.
  - addr_rd = IM2COL_BASE + k·DATA_WIDTH.
- **Accumulate**: on each READING edge, compute y = row+fr-P and x = col+fc-P.
  - If 0≤y<IMG_H and 0≤x<IMG_W: buf[ch·IMG_H·IMG_W + y·IMG_W + x] += data_rd.
  - Otherwise discard data_rd.
- **Arithmetic**: sums are modulo 2^DATA_WIDTH (wrap, no saturation). Signedness is irrelevant because the operation is two's-complement addition.
- **Write order**: index j = ch·IMG_H·IMG_W + y·IMG_W + x, ascending from 0 to NW-1.
  - addr_wr = IMG_BASE + j·DATA_WIDTH.
  - data_wr = buf[j].
- FILTER_SIZE=1 (P=0) degenerates to a plain copy with transposition from pixel-major/channel-minor to channel-major order.

## Timing
- **Reset values**: addr_rd=IM2COL_BASE, addr_wr=IMG_BASE, data_wr=0, mem_wr_en=0, done=0, state=IDLE, all counters 0, buffer 0.
- Cycle 0 is the first rising edge after rst_n deasserts; at cycle 0 the state goes IDLE→READING.
- **READING**: the read at cycle c (c=1..NR) samples data_rd at address IM2COL_BASE+(c-1)·DATA_WIDTH.
  - addr_rd advances by DATA_WIDTH on each READING edge.
  - After the last read, addr_rd holds its final value.
- **WRITING**:
  - mem_wr_en rises on the edge that performs the last read.
  - The first write presents j=0 in the cycle after that edge.
  - There are exactly NW consecutive cycles with mem_wr_en=1 and no gaps.
- **DONE**:
  - On the edge after the last write, mem_wr_en=0 and done=1, both registered.
  - Total time from cycle 0 to done=1 is 1+NR+NW edges; for the defaults that is 1+576+64 = 641.
- **Boundary conditions**
  - Counter wrap: every counter wraps to 0 at its maximum, so all are 0 when entering WRITING.
  - Reset mid-operation: rst_n low at any cycle forces reset values immediately, with no clock required. The next run restarts from IDLE with a cleared buffer and no partial writes.
  - Simultaneous events: there are none; reads and writes never overlap.
  - No stall or back-pressure: memory must accept one access per cycle.

## Test plan
- **All-ones matrix** (defaults, every im2col element=1) -> written image: interior pixel = 9, non-corner edge = 6, corner = 4. Exactly 64 writes at 0x0000..0x01F8, stride 8; done=1 at edge 641.
- **Round trip**: generate im2col of an image with pixel p(y,x)=y·8+x, then run col2im -> each output equals p·coverage, where coverage is 9/6/4 as above, mod 256.
- **Wrap**: every element = 0x20 -> interior pixel = 0x20 (9·32 = 288 mod 256), edge = 0xC0, corner = 0x80.
- **Channel separation**: IMG_C=2, ch0 elements=1, ch1 elements=2 -> the ch0 plane shows 9/6/4 and the ch1 plane shows 18/12/8. Each plane occupies 64 consecutive addresses, ch0 first.
- **Identity**: FILTER_SIZE=1, element k = k -> image[ch·64+y·8+x] = (y·8+x)·IMG_C+ch.
- **Reset mid-run**: assert rst_n low at READING cycle 200 and release -> outputs return to reset values immediately, no mem_wr_en pulse occurs, and a full rerun matches the all-ones result.

Source files
------------

// File: rtl/col2im.sv
// col2im: inverse of the im2col lowering stage.
//
// Streams an im2col matrix in from memory (one element per cycle), adds each
// element back into its source pixel of the zero-padded feature map, drops
// elements that land on padding, and then streams the accumulated image back
// out in channel-major order (one element per cycle).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   data_rd    memory read data, combinational function of addr_rd
//   addr_rd    registered read address
//   data_wr    registered write data
//   addr_wr    registered write address
//   mem_wr_en  write strobe, addr_wr/data_wr valid while high
//   done       sticky completion flag, cleared only by reset
module col2im #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int FILTER_SIZE = 3,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = 'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  mem_wr_en,
  output logic                  done
);

  localparam int NW  = IMG_C * IMG_H * IMG_W;
  localparam int PAD = (FILTER_SIZE - 1) / 2;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW  = 32;
  localparam int CW1 = CW + 1;

  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(IMG_C - 1);
  localparam logic [CW-1:0] FS_MAX  = CW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] NW_MAX  = CW'(NW - 1);
  localparam logic [CW-1:0] HW_U    = CW'(IMG_H * IMG_W);
  localparam logic [CW-1:0] W_U     = CW'(IMG_W);

  localparam logic signed [CW:0] PAD_S = CW1'(PAD);
  localparam logic signed [CW:0] H_S   = CW1'(IMG_H);
  localparam logic signed [CW:0] W_S   = CW1'(IMG_W);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READING,
    S_WRITING,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] ch_q,  ch_d;
  logic [CW-1:0] fr_q,  fr_d;
  logic [CW-1:0] fc_q,  fc_d;
  logic [CW-1:0] j_q,   j_d;

  logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
  logic [DATA_WIDTH-1:0] data_wr_q, data_wr_d;
  logic                  wr_en_q,   wr_en_d;
  logic                  done_q,    done_d;

  // Accumulator image, channel-major. Kept in flops because it has to clear
  // asynchronously on reset and in a single IDLE cycle.
  logic [DATA_WIDTH-1:0] acc_q [NW];
  logic [DATA_WIDTH-1:0] acc_d [NW];

  // Source pixel of the current im2col element, relative to the unpadded image.
  logic signed [CW:0] y_s, x_s;
  logic               in_img;
  logic [IW-1:0]      acc_idx;
  logic               last_rd;

  always_comb begin
    y_s     = $signed({1'b0, row_q}) + $signed({1'b0, fr_q}) - PAD_S;
    x_s     = $signed({1'b0, col_q}) + $signed({1'b0, fc_q}) - PAD_S;
    in_img  = !y_s[CW] && (y_s < H_S) && !x_s[CW] && (x_s < W_S);
    acc_idx = IW'(ch_q * HW_U + y_s[CW-1:0] * W_U + x_s[CW-1:0]);
    last_rd = (row_q == ROW_MAX) && (col_q == COL_MAX) && (ch_q == CH_MAX) &&
              (fr_q == FS_MAX) && (fc_q == FS_MAX);
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    ch_d      = ch_q;
    fr_d      = fr_q;
    fc_d      = fc_q;
    j_d       = j_q;
    addr_rd_d = addr_rd_q;
    addr_wr_d = addr_wr_q;
    data_wr_d = data_wr_q;
    wr_en_d   = wr_en_q;
    done_d    = done_q;
    acc_d     = acc_q;

    unique case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NW; i++) acc_d[i] = '0;
        state_d = S_READING;
      end

      S_READING: begin
        if (in_img) acc_d[acc_idx] = acc_q[acc_idx] + data_rd;

        // Nested counters, innermost first; all wrap to 0 after the last read.
        if (fc_q == FS_MAX) begin
          fc_d = '0;
          if (fr_q == FS_MAX) begin
            fr_d = '0;
            if (ch_q == CH_MAX) begin
              ch_d = '0;
              if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1;
              end else begin
                col_d = col_q + 1;
              end
            end else begin
              ch_d = ch_q + 1;
            end
          end else begin
            fr_d = fr_q + 1;
          end
        end else begin
          fc_d = fc_q + 1;
        end

        if (last_rd) begin
          // Preload the first write from the post-accumulation value so the
          // write stream starts in the very next cycle.
          state_d   = S_WRITING;
          wr_en_d   = 1'b1;
          j_d       = '0;
          addr_wr_d = IMG_BASE;
          data_wr_d = acc_d[0];
        end else begin
          addr_rd_d = addr_rd_q + STRIDE;
        end
      end

      S_WRITING: begin
        if (j_q == NW_MAX) begin
          state_d = S_DONE;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          j_d       = j_q + 1;
          addr_wr_d = addr_wr_q + STRIDE;
          data_wr_d = acc_q[IW'(j_q + 1)];
        end
      end

      S_DONE: begin
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      fr_q      <= '0;
      fc_q      <= '0;
      j_q       <= '0;
      addr_rd_q <= IM2COL_BASE;
      addr_wr_q <= IMG_BASE;
      data_wr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NW; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ch_q      <= ch_d;
      fr_q      <= fr_d;
      fc_q      <= fc_d;
      j_q       <= j_d;
      addr_rd_q <= addr_rd_d;
      addr_wr_q <= addr_wr_d;
      data_wr_q <= data_wr_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

  assign addr_rd   = addr_rd_q;
  assign addr_wr   = addr_wr_q;
  assign data_wr   = data_wr_q;
  assign mem_wr_en = wr_en_q;
  assign done      = done_q;

endmodule

// File: tb/tb_col2im.sv
// Testbench for col2im. Three instances share one clock:
//   inst 0: defaults (C=1, FS=3)  - all-ones, round trip, wrap, reset mid-run
//   inst 1: C=2, FS=3             - channel separation
//   inst 2: C=2, FS=1             - identity / transposition
// Each instance sees a behavioural memory whose read data is a function of
// addr_rd and the current stimulus mode. Expected writes are pushed to a
// scoreboard queue when a run starts and popped as writes appear.
module tb_col2im;

  logic        clk = 1'b0;
  logic [2:0]  rst_n_i = 3'b000;
  logic [7:0]  data_rd_i [3];
  logic [31:0] addr_rd_i [3];
  logic [7:0]  data_wr_i [3];
  logic [31:0] addr_wr_i [3];
  logic        wr_en_i   [3];
  logic        done_i    [3];
  int          mode_i    [3];

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  wr_cnt   = 0;

  always #5 clk = ~clk;

  col2im dut0 (
    .clk(clk), .rst_n(rst_n_i[0]), .data_rd(data_rd_i[0]), .addr_rd(addr_rd_i[0]),
    .data_wr(data_wr_i[0]), .addr_wr(addr_wr_i[0]), .mem_wr_en(wr_en_i[0]), .done(done_i[0])
  );

  col2im #(.IMG_C(2), .FILTER_SIZE(3)) dut1 (
    .clk(clk), .rst_n(rst_n_i[1]), .data_rd(data_rd_i[1]), .addr_rd(addr_rd_i[1]),
    .data_wr(data_wr_i[1]), .addr_wr(addr_wr_i[1]), .mem_wr_en(wr_en_i[1]), .done(done_i[1])
  );

  col2im #(.IMG_C(2), .FILTER_SIZE(1)) dut2 (
    .clk(clk), .rst_n(rst_n_i[2]), .data_rd(data_rd_i[2]), .addr_rd(addr_rd_i[2]),
    .data_wr(data_wr_i[2]), .addr_wr(addr_wr_i[2]), .mem_wr_en(wr_en_i[2]), .done(done_i[2])
  );

  function automatic int inst_c(input int inst);
    return (inst == 0) ? 1 : 2;
  endfunction

  function automatic int inst_fs(input int inst);
    return (inst == 2) ? 1 : 3;
  endfunction

  // Behavioural memory. Modes: 0 all ones, 1 im2col of p(y,x)=y*8+x,
  // 2 all 0x20, 3 channel value ch+1, 4 element k holds k.
  function automatic logic [7:0] mem_val(input int inst, input int mode, input logic [31:0] a);
    int c, fs, p, kk, k, fc, fr, ch, pix, col, row, y, x;
    c   = inst_c(inst);
    fs  = inst_fs(inst);
    p   = (fs - 1) / 2;
    kk  = fs * fs;
    k   = int'((a - 32'h2000) >> 3);
    fc  = k % fs;
    fr  = (k / fs) % fs;
    ch  = (k / kk) % c;
    pix = k / (kk * c);
    col = pix % 8;
    row = pix / 8;
    y   = row + fr - p;
    x   = col + fc - p;
    case (mode)
      0:       return 8'd1;
      1:       return (y >= 0 && y < 8 && x >= 0 && x < 8) ? 8'(y * 8 + x) : 8'd0;
      2:       return 8'h20;
      3:       return 8'(ch + 1);
      default: return 8'(k);
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) data_rd_i[i] = mem_val(i, mode_i[i], addr_rd_i[i]);
  end

  // Number of filter taps along one axis that reach coordinate v.
  function automatic int reach(input int v, input int p);
    int n;
    n = 0;
    for (int d = -p; d <= p; d++) if (v + d >= 0 && v + d < 8) n++;
    return n;
  endfunction

  function automatic int exp_val(input int inst, input int mode, input int j);
    int ch, y, x, cov;
    ch  = j / 64;
    y   = (j % 64) / 8;
    x   = j % 8;
    cov = reach(y, (inst_fs(inst) - 1) / 2) * reach(x, (inst_fs(inst) - 1) / 2);
    case (mode)
      0:       return cov % 256;
      1:       return ((y * 8 + x) * cov) % 256;
      2:       return (32 * cov) % 256;
      3:       return ((ch + 1) * cov) % 256;
      default: return ((y * 8 + x) * inst_c(inst) + ch) % 256;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: one line per observed write transaction.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en_i[i]) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(wr_en_i[i]), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("inst%0d wr addr=0x%04h data=0x%02h exp=0x%02h",
                   i, addr_wr_i[i], data_wr_i[i], mon_e.data);
          check("wr_addr", addr_wr_i[i], mon_e.addr);
          check("wr_data", 32'(data_wr_i[i]), mon_e.data);
        end
      end
    end
  end

  task automatic run(input int inst, input int mode, input int exp_done, input int exp_first);
    int nw, n, first;
    nw = inst_c(inst) * 64;
    mode_i[inst] = mode;
    for (int j = 0; j < nw; j++) exp_q.push_back('{addr: 32'(j * 8), data: 32'(exp_val(inst, mode, j))});
    rst_n_i[inst] = 1'b0;
    @(negedge clk);
    wr_cnt = 0;
    rst_n_i[inst] = 1'b1;
    n = 0;
    first = -1;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (wr_en_i[inst] && first < 0) first = n;
      if (done_i[inst] || n > exp_done + 200) break;
    end
    check("done_edge", 32'(n), 32'(exp_done));
    check("first_wr_edge", 32'(first), 32'(exp_first));
    @(negedge clk);
    check("wr_count", 32'(wr_cnt), 32'(nw));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("done_sticky", 32'(done_i[inst]), 32'd1);
    check("wr_en_after_done", 32'(wr_en_i[inst]), 32'd0);
    $display("run inst%0d mode%0d: done at edge %0d, %0d writes", inst, mode, n, wr_cnt);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mode_i[i] = 0;
    rst_n_i = 3'b000;
    @(negedge clk);
    check("rst_addr_rd", addr_rd_i[0], 32'h2000);
    check("rst_addr_wr", addr_wr_i[0], 32'h0000);
    check("rst_data_wr", 32'(data_wr_i[0]), 32'd0);
    check("rst_wr_en", 32'(wr_en_i[0]), 32'd0);
    check("rst_done", 32'(done_i[0]), 32'd0);

    run(0, 0, 641, 577);   // all ones
    run(0, 1, 641, 577);   // round trip
    run(0, 2, 641, 577);   // wrap

    // Reset in the middle of READING (edge 1 is IDLE, edges 2..201 are 200 reads).
    rst_n_i[0] = 1'b0;
    @(negedge clk);
    mode_i[0] = 0;
    rst_n_i[0] = 1'b1;
    repeat (201) @(posedge clk);
    #3;
    rst_n_i[0] = 1'b0;
    #1;
    check("midrst_addr_rd", addr_rd_i[0], 32'h2000);
    check("midrst_addr_wr", addr_wr_i[0], 32'h0000);
    check("midrst_data_wr", 32'(data_wr_i[0]), 32'd0);
    check("midrst_wr_en", 32'(wr_en_i[0]), 32'd0);
    check("midrst_done", 32'(done_i[0]), 32'd0);
    repeat (3) @(negedge clk);
    run(0, 0, 641, 577);   // full rerun after mid-run reset

    run(1, 3, 1281, 1153); // channel separation
    run(2, 4, 257, 129);   // identity with transposition

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
